studio2_keypad: RTL and testbench
=================================

# studio2_keypad

Keypad front end for the Studio II core. It converts PS/2 key events into two 10-key pressed bitmaps, latches the key-select nibble the CPU writes with OUT 2, and drives the active-low EF3/EF4 flags into the `cdp1802` EF input. The CPU polls a key by writing its number and then testing EF3 (keypad 1) or EF4 (keypad 2). A minimum-hold stretcher keeps short taps visible for a whole polling loop.

## Interface
- `MIN_HOLD`, default 100000: minimum clk_sys cycles a key stays asserted after its most recent press on that keypad. 0 disables stretching.
- `clk_sys` in 1: system clock; all logic on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `ps2_key` in 11: [10] event toggle, [9] pressed, [8] extended, [7:0] scan code.
- `io_out` in 1: CPU output strobe, one-cycle pulse.
- `io_n` in 3: CPU N lines for the current I/O instruction.
- `io_dout` in 8: CPU output data.
- `ef_kp_n` out 2: [0] = EF3 (keypad 1), [1] = EF4 (keypad 2); active-low; registered.
- `key_sel` out 4: latched key-select nibble.
- `kp1_keys` out 10: keypad 1 asserted keys; bit k = key k.
- `kp2_keys` out 10: keypad 2 asserted keys.

## Operation
- Reset values:
  - `ef_kp_n` = 2'b11.
  - `key_sel` = 4'h0.
  - `kp1_keys` and `kp2_keys` = 0.
  - Pending-release bitmaps = 0, both hold counters = 0, `armed` = 0.
- Event detect:
  - `prev_tog` is registered from `ps2_key[10]` every cycle.
  - An event fires when `armed` = 1 and `ps2_key[10]` != `prev_tog`.
  - `armed` is set on the first cycle after reset. This suppresses a spurious event from a toggle level that was already present at reset.
- Scan-code map, non-extended codes only:
  - Keypad 1: 16,1E,26,25,2E,36,3D,3E,46,45 → keys 1..9,0.
  - Keypad 2: 15,1D,24,2D,2C,35,3C,43,44,4D → keys 1..9,0.
  - Events with `ps2_key[8]` = 1, and any unlisted codes, are ignored.
- Press of key k on pad p:
  - keys_p[k] ← 1.
  - pend_p[k] ← 0.
  - cnt_p ← MIN_HOLD.
- Release of key k on pad p:
  - If cnt_p = 0, keys_p[k] ← 0.
  - Otherwise pend_p[k] ← 1; the key stays asserted.
- Counter per pad:
  - Each cycle with cnt_p > 0 and no press on pad p, cnt_p decrements.
  - When cnt_p = 1 on such a cycle (expiry): keys_p ← keys_p & ~pend_p, and pend_p ← 0.
- Simultaneous events:
  - A press on pad p in the expiry cycle reloads cnt_p. Expiry does not occur that cycle, and pend_p is retained except bit k.
  - A release in the expiry cycle uses the pre-expiry cnt_p value (nonzero), so it sets pend. That pend bit is then cleared by the same expiry, with keys bit cleared. Net result: the key is released this cycle.
- Pads are independent. A single PS/2 event affects at most one pad.
- Key select: when `io_out` = 1 and `io_n` = 3'd2, `key_sel` ← `io_dout[3:0]`. Other `io_n` values are ignored.
- Flags, registered every cycle:
  - `ef_kp_n[0]` ← ~(key_sel ≤ 9 && kp1_keys[key_sel]).
  - `ef_kp_n[1]` ← ~(key_sel ≤ 9 && kp2_keys[key_sel]).
  - `key_sel` values 10–15 give inactive (1) flags.

## Timing
- PS/2 event: keys bitmap updates at the edge where the toggle mismatch is sampled. `ef_kp_n` reflects it one edge later, i.e. 2 cycles from input change to flag.
- OUT 2: `key_sel` updates at the edge with `io_out` high. `ef_kp_n` follows one edge later.
- Hold: with MIN_HOLD = N, after a press at edge t followed by a release at t+1, the key clears at edge t+N, provided there is no further press on that pad.
- Asynchronous reset mid-operation clears everything immediately. After deassertion, the first toggle difference relative to the sampled level is required before any event is accepted.

## Test plan
- Reset, MIN_HOLD = 0, toggle with code 16 pressed → `kp1_keys` = 10'b0000000010. OUT 2 with `io_dout` = 8'h01 → `ef_kp_n` = 2'b10 one cycle after the `key_sel` update.
- Same setup, then release code 16 → `kp1_keys` = 0 at the event edge, `ef_kp_n` = 2'b11 one cycle later.
- MIN_HOLD = 8, press 4D then release 4D on the next cycle → `kp2_keys[0]` stays 1 for exactly 8 edges after the press. `ef_kp_n[1]` = 0 with `key_sel` = 0 throughout that window.
- MIN_HOLD = 8, press 1E, release 1E, press 26 at cycle 5 → the counter reloads. Keys 2 and 3 are both set until expiry at press(26) + 8, then only key 3 remains set.
- `io_n` = 3'd1 with `io_dout` = 8'h05 → `key_sel` unchanged. OUT 2 with 8'h0C while keys are held → `ef_kp_n` = 2'b11.
- Extended event (`ps2_key[8]` = 1, code 16) → no change. Reset asserted with `ps2_key[10]` = 1, then released with no toggle change → no event, all bitmaps remain 0.

Source files
------------

// File: rtl/studio2_keypad.sv
`default_nettype none
// ============================================================================
// Module      : studio2_keypad
// Description : Studio II keypad front end. Turns PS/2 key events into two
//               10-key pressed bitmaps with a minimum-hold stretcher, latches
//               the OUT 2 key-select nibble and drives active-low EF3/EF4.
// Revision    : 1.0 - initial release
// ============================================================================
module studio2_keypad #(
  parameter int MIN_HOLD = 100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        io_out,
  input  logic [2:0]  io_n,
  input  logic [7:0]  io_dout,
  output logic [1:0]  ef_kp_n,
  output logic [3:0]  key_sel,
  output logic [9:0]  kp1_keys,
  output logic [9:0]  kp2_keys
);

  // Counter must hold MIN_HOLD; keep at least one bit when stretching is off.
  localparam int              CNT_W     = (MIN_HOLD < 1) ? 1 : $clog2(MIN_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             prev_tog;
  logic             armed;
  logic             evt;
  logic [1:0]       hit_pad;
  logic [3:0]       hit_key;
  logic [9:0]       keys_q [2];
  logic [9:0]       pend_q [2];
  logic [CNT_W-1:0] cnt_q  [2];
  logic [9:0]       keys_d [2];
  logic [9:0]       pend_d [2];
  logic [CNT_W-1:0] cnt_d  [2];
  logic [15:0]      kp1_ext;
  logic [15:0]      kp2_ext;

  // A toggle edge only counts once the level has been sampled at least once.
  assign evt = armed && (ps2_key[10] != prev_tog);

  // Map non-extended scan codes to (pad, key); unlisted codes hit no pad.
  always_comb begin
    hit_pad = 2'b00;
    hit_key = 4'd0;
    if (!ps2_key[8]) begin
      case (ps2_key[7:0])
        8'h16: begin hit_pad = 2'b01; hit_key = 4'd1; end
        8'h1E: begin hit_pad = 2'b01; hit_key = 4'd2; end
        8'h26: begin hit_pad = 2'b01; hit_key = 4'd3; end
        8'h25: begin hit_pad = 2'b01; hit_key = 4'd4; end
        8'h2E: begin hit_pad = 2'b01; hit_key = 4'd5; end
        8'h36: begin hit_pad = 2'b01; hit_key = 4'd6; end
        8'h3D: begin hit_pad = 2'b01; hit_key = 4'd7; end
        8'h3E: begin hit_pad = 2'b01; hit_key = 4'd8; end
        8'h46: begin hit_pad = 2'b01; hit_key = 4'd9; end
        8'h45: begin hit_pad = 2'b01; hit_key = 4'd0; end
        8'h15: begin hit_pad = 2'b10; hit_key = 4'd1; end
        8'h1D: begin hit_pad = 2'b10; hit_key = 4'd2; end
        8'h24: begin hit_pad = 2'b10; hit_key = 4'd3; end
        8'h2D: begin hit_pad = 2'b10; hit_key = 4'd4; end
        8'h2C: begin hit_pad = 2'b10; hit_key = 4'd5; end
        8'h35: begin hit_pad = 2'b10; hit_key = 4'd6; end
        8'h3C: begin hit_pad = 2'b10; hit_key = 4'd7; end
        8'h43: begin hit_pad = 2'b10; hit_key = 4'd8; end
        8'h44: begin hit_pad = 2'b10; hit_key = 4'd9; end
        8'h4D: begin hit_pad = 2'b10; hit_key = 4'd0; end
        default: begin hit_pad = 2'b00; hit_key = 4'd0; end
      endcase
    end
  end

  // Per-pad next state: press reloads the hold, release waits for expiry.
  // A release landing on the expiry cycle sets pend and is then cleared by
  // that same expiry, so the key drops this cycle.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      keys_d[p] = keys_q[p];
      pend_d[p] = pend_q[p];
      cnt_d[p]  = cnt_q[p];
      if (evt && hit_pad[p] && ps2_key[9]) begin
        keys_d[p][hit_key] = 1'b1;
        pend_d[p][hit_key] = 1'b0;
        cnt_d[p]           = HOLD_LOAD;
      end else begin
        if (evt && hit_pad[p]) begin
          if (cnt_q[p] == '0) keys_d[p][hit_key] = 1'b0;
          else                pend_d[p][hit_key] = 1'b1;
        end
        if (cnt_q[p] != '0) begin
          cnt_d[p] = cnt_q[p] - CNT_ONE;
          if (cnt_q[p] == CNT_ONE) begin
            keys_d[p] = keys_d[p] & ~pend_d[p];
            pend_d[p] = '0;
          end
        end
      end
    end
  end

  // Zero-extend so key_sel 10..15 reads an inactive key.
  assign kp1_ext  = {6'b0, keys_q[0]};
  assign kp2_ext  = {6'b0, keys_q[1]};
  assign kp1_keys = keys_q[0];
  assign kp2_keys = keys_q[1];

  // State registers: event detect, bitmaps, hold counters, key select, flags.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prev_tog <= 1'b0;
      armed    <= 1'b0;
      key_sel  <= 4'h0;
      ef_kp_n  <= 2'b11;
      for (int p = 0; p < 2; p++) begin
        keys_q[p] <= '0;
        pend_q[p] <= '0;
        cnt_q[p]  <= '0;
      end
    end else begin
      prev_tog <= ps2_key[10];
      armed    <= 1'b1;
      if (io_out && (io_n == 3'd2)) key_sel <= io_dout[3:0];
      ef_kp_n  <= {~kp2_ext[key_sel], ~kp1_ext[key_sel]};
      for (int p = 0; p < 2; p++) begin
        keys_q[p] <= keys_d[p];
        pend_q[p] <= pend_d[p];
        cnt_q[p]  <= cnt_d[p];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_studio2_keypad.sv
`default_nettype none
// ============================================================================
// Module      : tb_studio2_keypad
// Description : Scoreboard bench for studio2_keypad. Two instances
//               (MIN_HOLD = 0 and 8) share stimulus; a time-based reference
//               model queues expected outputs per edge, a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_studio2_keypad;

  localparam int HOLD_B = 8;

  typedef struct packed {
    logic [1:0] ef;
    logic [3:0] ks;
    logic [9:0] k1;
    logic [9:0] k2;
  } obs_t;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        io_out;
  logic [2:0]  io_n;
  logic [7:0]  io_dout;
  logic [1:0]  ef_a, ef_b;
  logic [3:0]  ks_a, ks_b;
  logic [9:0]  k1_a, k1_b, k2_a, k2_b;

  int checks = 0;
  int errors = 0;

  obs_t exp_q [2][$];

  // Scan code of key k on pad p.
  logic [7:0] kp_code [2][10] = '{
    '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46},
    '{8'h4D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44}
  };

  always #5 clk_sys = ~clk_sys;

  studio2_keypad #(.MIN_HOLD(0)) dut_a (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .io_out(io_out),
    .io_n(io_n), .io_dout(io_dout), .ef_kp_n(ef_a), .key_sel(ks_a),
    .kp1_keys(k1_a), .kp2_keys(k2_a)
  );

  studio2_keypad #(.MIN_HOLD(HOLD_B)) dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .io_out(io_out),
    .io_n(io_n), .io_dout(io_dout), .ef_kp_n(ef_b), .key_sel(ks_b),
    .kp1_keys(k1_b), .kp2_keys(k2_b)
  );

  // Reference model: each key remembers whether it is held; released keys
  // linger until the pad's "hold until" edge number (last press + MIN_HOLD).
  int       m_hold [2] = '{0, HOLD_B};
  bit [9:0] m_keys [2][2];
  bit [9:0] m_pend [2][2];
  longint   m_until [2][2];
  bit [1:0] m_ef [2];
  bit [3:0] m_ks;
  bit       m_prev;
  int       m_edges;
  longint   cyc = 0;

  initial begin
    forever begin
      @(posedge clk_sys);
      cyc++;
      if (!reset_n) begin
        for (int d = 0; d < 2; d++) begin
          m_ef[d] = 2'b11;
          for (int p = 0; p < 2; p++) begin
            m_keys[d][p] = '0; m_pend[d][p] = '0; m_until[d][p] = 0;
          end
        end
        m_ks = 4'h0; m_prev = 1'b0; m_edges = 0;
      end else begin
        bit evt, found;
        int fp, fk;
        for (int d = 0; d < 2; d++) begin
          bit a1, a2;
          a1 = (m_ks <= 9) ? m_keys[d][0][m_ks] : 1'b0;
          a2 = (m_ks <= 9) ? m_keys[d][1][m_ks] : 1'b0;
          m_ef[d] = {~a2, ~a1};
        end
        evt = (m_edges >= 1) && (ps2_key[10] != m_prev);
        m_prev = ps2_key[10];
        m_edges++;
        found = 1'b0; fp = 0; fk = 0;
        if (evt && !ps2_key[8])
          for (int p = 0; p < 2; p++)
            for (int k = 0; k < 10; k++)
              if (kp_code[p][k] == ps2_key[7:0]) begin found = 1'b1; fp = p; fk = k; end
        for (int d = 0; d < 2; d++)
          for (int p = 0; p < 2; p++) begin
            if (found && fp == p && ps2_key[9]) begin
              m_keys[d][p][fk] = 1'b1;
              m_pend[d][p][fk] = 1'b0;
              m_until[d][p] = cyc + m_hold[d];
            end else begin
              if (found && fp == p) begin
                if (cyc >= m_until[d][p]) m_keys[d][p][fk] = 1'b0;
                else m_pend[d][p][fk] = 1'b1;
              end
              if (cyc == m_until[d][p]) begin
                m_keys[d][p] = m_keys[d][p] & ~m_pend[d][p];
                m_pend[d][p] = '0;
              end
            end
          end
        if (io_out && io_n == 3'd2) m_ks = io_dout[3:0];
      end
      for (int d = 0; d < 2; d++)
        exp_q[d].push_back('{ef: m_ef[d], ks: m_ks, k1: m_keys[d][0], k2: m_keys[d][1]});
    end
  end

  task automatic check(input string name, input int d, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, d, $time, act, expv);
    end
  endtask

  // Monitor: every edge is an output presentation; pop and compare.
  initial begin
    forever begin
      @(posedge clk_sys);
      #2;
      for (int d = 0; d < 2; d++) begin
        obs_t e;
        obs_t a;
        a = (d == 0) ? '{ef: ef_a, ks: ks_a, k1: k1_a, k2: k2_a}
                     : '{ef: ef_b, ks: ks_b, k1: k1_b, k2: k2_b};
        if (exp_q[d].size() == 0) begin
          check("queue_empty", d, 16'd0, 16'd1);
        end else begin
          e = exp_q[d].pop_front();
          check("ef_kp_n", d, {14'd0, a.ef}, {14'd0, e.ef});
          check("key_sel", d, {12'd0, a.ks}, {12'd0, e.ks});
          check("kp1_keys", d, {6'd0, a.k1}, {6'd0, e.k1});
          check("kp2_keys", d, {6'd0, a.k2}, {6'd0, e.k2});
        end
      end
    end
  end

  task automatic step();
    @(negedge clk_sys);
    io_out = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic key(input logic [7:0] code, input logic pressed, input logic ext);
    step();
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic cpu_out(input logic [2:0] n, input logic [7:0] d);
    step();
    io_out = 1'b1; io_n = n; io_dout = d;
  endtask

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    reset_n = 1'b0; ps2_key = '0; io_out = 1'b0; io_n = 3'd0; io_dout = 8'h00;
    idle(3);
    reset_n = 1'b1;
    idle(2);
    key(8'h16, 1'b1, 1'b0); cpu_out(3'd2, 8'h01); idle(3);
    key(8'h16, 1'b0, 1'b0); idle(3);
    cpu_out(3'd2, 8'h00); key(8'h4D, 1'b1, 1'b0); key(8'h4D, 1'b0, 1'b0); idle(12);
    key(8'h1E, 1'b1, 1'b0); key(8'h1E, 1'b0, 1'b0); idle(2);
    key(8'h26, 1'b1, 1'b0); idle(12); key(8'h26, 1'b0, 1'b0); idle(10);
    cpu_out(3'd1, 8'h05); key(8'h16, 1'b1, 1'b0); cpu_out(3'd2, 8'h0C); idle(3);
    key(8'h16, 1'b0, 1'b0); idle(10);
    cpu_out(3'd2, 8'h01); key(8'h16, 1'b1, 1'b1); idle(3);
    key(8'h45, 1'b1, 1'b0); idle(2);
    step(); ps2_key[10] = 1'b1;
    step(); reset_n = 1'b0; idle(3);
    step(); reset_n = 1'b1; idle(5);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (i == 1500) begin
        step(); reset_n = 1'b0; idle(2); step(); reset_n = 1'b1;
      end else if (r <= 3) begin
        logic [7:0] c;
        if ($urandom_range(0, 4) != 0) c = kp_code[$urandom_range(0, 1)][$urandom_range(0, 9)];
        else c = 8'($urandom_range(0, 255));
        key(c, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      end else if (r <= 5) begin
        cpu_out(($urandom_range(0, 9) < 7) ? 3'd2 : 3'($urandom_range(0, 7)),
                {4'($urandom_range(0, 15)), 4'($urandom_range(0, 11))});
      end else begin
        idle($urandom_range(1, 3));
      end
    end
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
